// File: rtl/elevator_call_panel.sv
// Elevator cabin/landing panel front end: synchronizes raw buttons and toggle switches,
// debounces calls into a latched request register, and tracks occupancy, overweight and SOS.
module elevator_call_panel #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MAX_PEOPLE      = 6,
   parameter int COUNT_W         = 4
) (
   input  logic               clk_50,
   input  logic               rst_n,
   input  logic               button1,
   input  logic               button2,
   input  logic               button3,
   input  logic               sos_flip,
   input  logic               weight_flip,
   input  logic               weight_flip_reset,
   input  logic [2:0]         floor,
   input  logic               door,
   output logic [2:0]         call_req,
   output logic               led1,
   output logic               led2,
   output logic               led3,
   output logic [COUNT_W-1:0] people_count,
   output logic               sos_mode,
   output logic               weight_limit_exceeded
);

   typedef enum logic [1:0] {IDLE, CHECK, HELD} btn_state_t;

   localparam logic [7:0]       DEB_LEN  = 8'(DEBOUNCE_CYCLES);
   localparam logic [COUNT_W:0] MAX_PPL  = (COUNT_W+1)'(MAX_PEOPLE);
   localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   logic [2:0]         btn_p0, btn_p1;
   // flip bit 0 = sos, bit 1 = weight, bit 2 = weight reset
   logic [2:0]         flip_p0, flip_p1, flip_prev;
   logic [1:0]         arm_cnt;
   logic               armed;
   logic [2:0]         flip_evt;

   btn_state_t         state_q [3];
   btn_state_t         state_d [3];
   logic [7:0]         cnt_q   [3];
   logic [7:0]         cnt_d   [3];
   logic [2:0]         press;

   logic [2:0]         call_q, call_d, clear, set;
   logic               sos_q, sos_d, sos_rise;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               wle_q, wle_d;

   // ---- synchronizer stages ----
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         btn_p0    <= 3'b111;
         btn_p1    <= 3'b111;
         flip_p0   <= 3'b000;
         flip_p1   <= 3'b000;
         flip_prev <= 3'b000;
         arm_cnt   <= 2'd0;
      end else begin
         btn_p0    <= {button3, button2, button1};
         btn_p1    <= btn_p0;
         flip_p0   <= {weight_flip_reset, weight_flip, sos_flip};
         flip_p1   <= flip_p0;
         flip_prev <= flip_p1;
         if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
      end
   end

   // Arming waits for the synchronizer to fill so levels held through reset make no event.
   assign armed    = (arm_cnt == 2'd3);
   assign flip_evt = armed ? (flip_p1 ^ flip_prev) : 3'b000;

   // ---- button debounce FSMs ----
   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            state_q[i] <= IDLE;
            cnt_q[i]   <= 8'd0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   always_comb begin
      press = 3'b000;
      for (int i = 0; i < 3; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            IDLE: begin
               if (!btn_p1[i]) begin
                  state_d[i] = CHECK;
                  cnt_d[i]   = 8'd1;
               end
            end
            CHECK: begin
               if (btn_p1[i]) begin
                  state_d[i] = IDLE;
               end else if (cnt_q[i] == DEB_LEN) begin
                  press[i]   = 1'b1;
                  state_d[i] = HELD;
               end else begin
                  cnt_d[i] = cnt_q[i] + 8'd1;
               end
            end
            HELD: begin
               if (btn_p1[i]) state_d[i] = IDLE;
            end
            default: state_d[i] = IDLE;
         endcase
      end
   end

   // ---- call latch, SOS and occupancy ----
   always_comb begin
      clear    = floor & {3{door}};
      set      = press & ~clear & {3{~sos_q & ~wle_q}};
      sos_rise = flip_evt[0] & ~sos_q;
      sos_d    = sos_q ^ flip_evt[0];
      call_d   = sos_rise ? 3'b000 : ((call_q & ~clear) | set);
      count_d  = count_q;
      if (flip_evt[2])      count_d = '0;
      else if (flip_evt[1]) count_d = sat_inc(count_q);
      wle_d    = ({1'b0, count_d} > MAX_PPL);
   end

   always_ff @(posedge clk_50 or negedge rst_n) begin
      if (!rst_n) begin
         call_q  <= 3'b000;
         sos_q   <= 1'b0;
         count_q <= '0;
         wle_q   <= 1'b0;
      end else begin
         call_q  <= call_d;
         sos_q   <= sos_d;
         count_q <= count_d;
         wle_q   <= wle_d;
      end
   end

   assign call_req              = call_q;
   assign led1                  = call_q[0];
   assign led2                  = call_q[1];
   assign led3                  = call_q[2];
   assign people_count          = count_q;
   assign sos_mode              = sos_q;
   assign weight_limit_exceeded = wle_q;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed vector bench for elevator_call_panel (DEBOUNCE_CYCLES=4, MAX_PEOPLE=6, COUNT_W=4).
module tb_elevator_call_panel;

   logic       clk_50 = 1'b0;
   logic       rst_n;
   logic       button1, button2, button3;
   logic       sos_flip, weight_flip, weight_flip_reset;
   logic [2:0] floor;
   logic       door;
   logic [2:0] call_req;
   logic       led1, led2, led3;
   logic [3:0] people_count;
   logic       sos_mode;
   logic       weight_limit_exceeded;

   int n_cmp  = 0;
   int n_fail = 0;

   elevator_call_panel #(
      .DEBOUNCE_CYCLES(4),
      .MAX_PEOPLE     (6),
      .COUNT_W        (4)
   ) dut (
      .clk_50               (clk_50),
      .rst_n                (rst_n),
      .button1              (button1),
      .button2              (button2),
      .button3              (button3),
      .sos_flip             (sos_flip),
      .weight_flip          (weight_flip),
      .weight_flip_reset    (weight_flip_reset),
      .floor                (floor),
      .door                 (door),
      .call_req             (call_req),
      .led1                 (led1),
      .led2                 (led2),
      .led3                 (led3),
      .people_count         (people_count),
      .sos_mode             (sos_mode),
      .weight_limit_exceeded(weight_limit_exceeded)
   );

   always #5 clk_50 = ~clk_50;

   typedef struct {
      logic [2:0] btn;   // {button3, button2, button1}, active-low
      logic       sos;
      logic       wf;
      logic       wfr;
      logic [2:0] flr;
      logic       door;
      int         hold;
      logic [2:0] ec;
      logic [3:0] en;
      logic       es;
      logic       ew;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [2:0] btn, input logic sos, input logic wf,
                               input logic wfr, input logic [2:0] flr, input logic dr,
                               input int hold, input logic [2:0] ec, input logic [3:0] en,
                               input logic es, input logic ew);
      vec_t v;
      v.btn = btn; v.sos = sos; v.wf = wf; v.wfr = wfr; v.flr = flr; v.door = dr;
      v.hold = hold; v.ec = ec; v.en = en; v.es = es; v.ew = ew;
      return v;
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk_50);
   endtask

   task automatic check(input string name, input logic [2:0] ec, input logic [3:0] en,
                        input logic es, input logic ew);
      logic [11:0] act, exp;
      act = {call_req, led3, led2, led1, people_count, sos_mode, weight_limit_exceeded};
      exp = {ec, ec, en, es, ew};
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got call=%b leds=%b%b%b cnt=%0d sos=%b wle=%b, want call=%b leds=%b cnt=%0d sos=%b wle=%b",
                  name, call_req, led3, led2, led1, people_count, sos_mode, weight_limit_exceeded,
                  ec, ec, en, es, ew);
      end
   endtask

   task automatic apply(input vec_t v);
      {button3, button2, button1} = v.btn;
      sos_flip          = v.sos;
      weight_flip       = v.wf;
      weight_flip_reset = v.wfr;
      floor             = v.flr;
      door              = v.door;
   endtask

   initial begin
      // rows continue from the state left by the button3 latency sequence
      vecs.push_back(mk(3'b110,0,0,0,3'b000,0, 3, 3'b000,4'd0,0,0)); // button1 short glitch
      vecs.push_back(mk(3'b111,0,0,0,3'b000,0, 8, 3'b000,4'd0,0,0));
      vecs.push_back(mk(3'b101,0,0,0,3'b000,0, 8, 3'b010,4'd0,0,0)); // button2 full press
      vecs.push_back(mk(3'b111,0,0,0,3'b000,0, 4, 3'b010,4'd0,0,0));
      vecs.push_back(mk(3'b111,0,1,0,3'b000,0, 4, 3'b010,4'd1,0,0)); // seven weight toggles
      vecs.push_back(mk(3'b111,0,0,0,3'b000,0, 4, 3'b010,4'd2,0,0));
      vecs.push_back(mk(3'b111,0,1,0,3'b000,0, 4, 3'b010,4'd3,0,0));
      vecs.push_back(mk(3'b111,0,0,0,3'b000,0, 4, 3'b010,4'd4,0,0));
      vecs.push_back(mk(3'b111,0,1,0,3'b000,0, 4, 3'b010,4'd5,0,0));
      vecs.push_back(mk(3'b111,0,0,0,3'b000,0, 4, 3'b010,4'd6,0,0));
      vecs.push_back(mk(3'b111,0,1,0,3'b000,0, 4, 3'b010,4'd7,0,1));
      vecs.push_back(mk(3'b011,0,1,0,3'b000,0, 8, 3'b010,4'd7,0,1)); // overweight blocks press
      vecs.push_back(mk(3'b111,0,1,0,3'b000,0, 4, 3'b010,4'd7,0,1));
      vecs.push_back(mk(3'b111,0,1,1,3'b000,0, 4, 3'b010,4'd0,0,0)); // occupancy clear
      vecs.push_back(mk(3'b011,0,1,1,3'b000,0, 8, 3'b110,4'd0,0,0));
      vecs.push_back(mk(3'b111,0,1,1,3'b000,0, 4, 3'b110,4'd0,0,0));
      vecs.push_back(mk(3'b110,0,1,1,3'b000,0, 8, 3'b111,4'd0,0,0));
      vecs.push_back(mk(3'b111,0,1,1,3'b000,0, 4, 3'b111,4'd0,0,0));
      vecs.push_back(mk(3'b110,0,1,1,3'b001,1, 8, 3'b110,4'd0,0,0)); // press at open-door floor
      vecs.push_back(mk(3'b111,0,1,1,3'b000,0, 4, 3'b110,4'd0,0,0));
      vecs.push_back(mk(3'b111,1,1,1,3'b000,0, 2, 3'b110,4'd0,0,0)); // SOS not yet through sync
      vecs.push_back(mk(3'b111,1,1,1,3'b000,0, 1, 3'b000,4'd0,1,0)); // SOS rises, calls cleared
      vecs.push_back(mk(3'b011,1,1,1,3'b000,0, 8, 3'b000,4'd0,1,0)); // press ignored in SOS
      vecs.push_back(mk(3'b111,1,1,1,3'b000,0, 4, 3'b000,4'd0,1,0));
      vecs.push_back(mk(3'b111,0,1,1,3'b000,0, 4, 3'b000,4'd0,0,0)); // SOS exit, calls stay clear
      vecs.push_back(mk(3'b011,0,1,1,3'b000,0, 8, 3'b100,4'd0,0,0));
      vecs.push_back(mk(3'b111,0,1,1,3'b000,0, 4, 3'b100,4'd0,0,0));
      vecs.push_back(mk(3'b111,0,0,1,3'b000,0, 4, 3'b100,4'd1,0,0));
      vecs.push_back(mk(3'b111,0,1,1,3'b000,0, 4, 3'b100,4'd2,0,0));
      vecs.push_back(mk(3'b111,0,0,1,3'b000,0, 4, 3'b100,4'd3,0,0));
      vecs.push_back(mk(3'b111,0,1,0,3'b000,0, 4, 3'b100,4'd0,0,0)); // simultaneous: reset wins

      rst_n = 1'b0;
      apply(mk(3'b111,0,0,0,3'b000,0, 0, 3'b000,4'd0,0,0));
      tick(3);
      check("reset_state", 3'b000, 4'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick(20);
      check("idle_20", 3'b000, 4'd0, 1'b0, 1'b0);

      // button3 press latency: rises on the 7th posedge after driving low
      button3 = 1'b0;
      tick(6);
      check("b3_before_latency", 3'b000, 4'd0, 1'b0, 1'b0);
      tick(1);
      check("b3_at_latency", 3'b100, 4'd0, 1'b0, 1'b0);
      tick(3);
      floor = 3'b100; door = 1'b1;
      tick(1);
      check("b3_cleared_by_door", 3'b000, 4'd0, 1'b0, 1'b0);
      floor = 3'b000; door = 1'b0;
      tick(6);
      check("b3_held_single_pulse", 3'b000, 4'd0, 1'b0, 1'b0);
      button3 = 1'b1;
      tick(4);

      for (int k = 0; k < vecs.size(); k++) begin
         apply(vecs[k]);
         tick(vecs[k].hold);
         check($sformatf("vec%0d", k), vecs[k].ec, vecs[k].en, vecs[k].es, vecs[k].ew);
      end

      // twenty weight toggles saturate at 15
      for (int i = 1; i <= 20; i++) begin
         logic [3:0] ecnt;
         weight_flip = ~weight_flip;
         tick(4);
         ecnt = (i > 15) ? 4'd15 : 4'(i);
         check($sformatf("sat%0d", i), 3'b100, ecnt, 1'b0, (ecnt > 4'd6));
      end

      // reset asserted mid-press, button1 held low through release
      button1 = 1'b0;
      tick(4);
      #2 rst_n = 1'b0;
      #1 check("async_reset", 3'b000, 4'd0, 1'b0, 1'b0);
      tick(2);
      rst_n = 1'b1;
      tick(6);
      check("post_reset_no_early_pulse", 3'b000, 4'd0, 1'b0, 1'b0);
      tick(1);
      check("post_reset_full_debounce", 3'b001, 4'd0, 1'b0, 1'b0);
      button1 = 1'b1;
      tick(4);
      check("post_reset_held_flip_no_event", 3'b001, 4'd0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
